can_arb_tx: RTL and testbench

CAN_ARB_TX -- requirements
Module: can_arb_tx

---
 rtl/can_pkg.sv | 25 ++
 rtl/can_arb_shifter.sv | 56 +++++
 rtl/can_arb_tx.sv | 139 +++++++++++++
 tb/tb_can_arb_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN arbitration-field transmitter.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LOST = 2'd2,
        DONE = 2'd3
    } can_arb_state_t;

    localparam int CAN_BASE_ID_W    = 11;
    localparam int CAN_EXT_ID_W     = 18;
    localparam int CAN_ARB_LEN_BASE = 12;
    localparam int CAN_ARB_LEN_EXT  = 32;
    localparam int CAN_CNT_W        = 6;

    // Base field left-aligned in the shift register, unused tail recessive.
    function automatic logic [CAN_ARB_LEN_EXT-1:0] can_base_field(
        input logic [CAN_BASE_ID_W-1:0] id,
        input logic                     rtr
    );
        return {id, rtr, {(CAN_ARB_LEN_EXT - CAN_ARB_LEN_BASE){1'b1}}};
    endfunction

endpackage

// File: rtl/can_arb_shifter.sv
// Arbitration-field shift register and bit counter; MSB is the bit on the bus.
module can_arb_shifter
    import can_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       load_ext,
    input  logic [CAN_ARB_LEN_EXT-1:0] load_data,
    input  logic                       advance,
    output logic                       cur_bit,
    output logic                       next_bit,
    output logic                       last_bit
);

    logic [CAN_ARB_LEN_EXT-1:0] shift_q, shift_d;
    logic [CAN_CNT_W-1:0]       count_q, count_d;
    logic                       ext_q, ext_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        ext_d   = ext_q;
        if (clear) begin
            shift_d = '1;
            count_d = '0;
            ext_d   = 1'b0;
        end else if (load) begin
            shift_d = load_data;
            count_d = '0;
            ext_d   = load_ext;
        end else if (advance) begin
            shift_d = {shift_q[CAN_ARB_LEN_EXT-2:0], 1'b1};
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '1;
            count_q <= '0;
            ext_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            ext_q   <= ext_d;
        end
    end

    assign cur_bit  = shift_q[CAN_ARB_LEN_EXT-1];
    assign next_bit = shift_q[CAN_ARB_LEN_EXT-2];
    assign last_bit = (count_q == (ext_q ? CAN_CNT_W'(CAN_ARB_LEN_EXT - 1)
                                         : CAN_CNT_W'(CAN_ARB_LEN_BASE - 1)));

endmodule

// File: rtl/can_arb_tx.sv
// CAN arbitration-field transmitter: sends ID/RTR, detects lost arbitration and bit errors.
// Define CAN_EXT_ID_EN to add the 29-bit extended identifier (tx_ide, tx_id_ext).
module can_arb_tx
    import can_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     sof_complete,
    input  logic                     sample_point,
    input  logic                     rx_bit,
    input  logic [CAN_BASE_ID_W-1:0] tx_id,
    input  logic                     tx_rtr,
`ifdef CAN_EXT_ID_EN
    input  logic                     tx_ide,
    input  logic [CAN_EXT_ID_W-1:0]  tx_id_ext,
`endif
    output logic                     tx_bit,
    output logic                     arb_active,
    output logic                     arb_complete,
    output logic                     arb_lost,
    output logic                     bit_error
);

    can_arb_state_t state_q, state_d;
    logic tx_bit_q, tx_bit_d;
    logic arb_active_q, arb_active_d;
    logic arb_complete_q, arb_complete_d;
    logic arb_lost_q, arb_lost_d;
    logic bit_error_q, bit_error_d;

    logic                       sh_clear, sh_load, sh_advance, sh_load_ext;
    logic [CAN_ARB_LEN_EXT-1:0] sh_load_data;
    logic                       sh_cur_bit, sh_next_bit, sh_last_bit;

`ifdef CAN_EXT_ID_EN
    assign sh_load_ext  = tx_ide;
    assign sh_load_data = tx_ide ? {tx_id, 1'b1, 1'b1, tx_id_ext, tx_rtr}
                                 : can_base_field(tx_id, tx_rtr);
`else
    assign sh_load_ext  = 1'b0;
    assign sh_load_data = can_base_field(tx_id, tx_rtr);
`endif

    can_arb_shifter u_shifter (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (sh_clear),
        .load      (sh_load),
        .load_ext  (sh_load_ext),
        .load_data (sh_load_data),
        .advance   (sh_advance),
        .cur_bit   (sh_cur_bit),
        .next_bit  (sh_next_bit),
        .last_bit  (sh_last_bit)
    );

    always_comb begin
        state_d        = state_q;
        tx_bit_d       = 1'b1;
        arb_active_d   = 1'b0;
        arb_complete_d = 1'b0;
        arb_lost_d     = 1'b0;
        bit_error_d    = 1'b0;
        sh_clear       = 1'b0;
        sh_load        = 1'b0;
        sh_advance     = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            sh_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A coincident sample_point is deliberately not looked at here.
                    if (sof_complete) begin
                        sh_load      = 1'b1;
                        state_d      = SEND;
                        tx_bit_d     = tx_id[CAN_BASE_ID_W-1];
                        arb_active_d = 1'b1;
                    end
                end
                SEND: begin
                    tx_bit_d     = tx_bit_q;
                    arb_active_d = 1'b1;
                    if (sample_point) begin
                        if (sh_cur_bit && !rx_bit) begin
                            state_d      = LOST;
                            arb_lost_d   = 1'b1;
                            tx_bit_d     = 1'b1;
                            arb_active_d = 1'b0;
                        end else if (!sh_cur_bit && rx_bit) begin
                            state_d      = IDLE;
                            bit_error_d  = 1'b1;
                            tx_bit_d     = 1'b1;
                            arb_active_d = 1'b0;
                        end else if (sh_last_bit) begin
                            state_d        = DONE;
                            arb_complete_d = 1'b1;
                            tx_bit_d       = 1'b1;
                            arb_active_d   = 1'b0;
                        end else begin
                            sh_advance = 1'b1;
                            tx_bit_d   = sh_next_bit;
                        end
                    end
                end
                LOST:    state_d = IDLE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            tx_bit_q       <= 1'b1;
            arb_active_q   <= 1'b0;
            arb_complete_q <= 1'b0;
            arb_lost_q     <= 1'b0;
            bit_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_bit_q       <= tx_bit_d;
            arb_active_q   <= arb_active_d;
            arb_complete_q <= arb_complete_d;
            arb_lost_q     <= arb_lost_d;
            bit_error_q    <= bit_error_d;
        end
    end

    assign tx_bit       = tx_bit_q;
    assign arb_active   = arb_active_q;
    assign arb_complete = arb_complete_q;
    assign arb_lost     = arb_lost_q;
    assign bit_error    = bit_error_q;

endmodule

// File: tb/tb_can_arb_tx.sv
// Self-checking bench for can_arb_tx against a bit-list model of the arbitration field.
module tb_can_arb_tx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sof_complete;
    logic        sample_point;
    logic        rx_bit;
    logic [10:0] tx_id;
    logic        tx_rtr;
`ifdef CAN_EXT_ID_EN
    logic        tx_ide;
    logic [17:0] tx_id_ext;
`endif
    logic        tx_bit;
    logic        arb_active;
    logic        arb_complete;
    logic        arb_lost;
    logic        bit_error;

    int errors = 0;
    int checks = 0;

    logic exp_bits[32];
    int   exp_len;

    always #5 clock = ~clock;

    can_arb_tx dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sof_complete (sof_complete),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_id        (tx_id),
        .tx_rtr       (tx_rtr),
`ifdef CAN_EXT_ID_EN
        .tx_ide       (tx_ide),
        .tx_id_ext    (tx_id_ext),
`endif
        .tx_bit       (tx_bit),
        .arb_active   (arb_active),
        .arb_complete (arb_complete),
        .arb_lost     (arb_lost),
        .bit_error    (bit_error)
    );

    // Expected on-bus sequence: ID MSB first, then SRR/IDE/ext ID for extended, then RTR.
    task automatic build_field(input logic [10:0] id, input logic rtr,
                               input logic ide, input logic [17:0] ext);
        exp_len = 0;
        for (int i = 10; i >= 0; i--) begin exp_bits[exp_len] = id[i]; exp_len++; end
        if (ide) begin
            exp_bits[exp_len] = 1'b1; exp_len++;
            exp_bits[exp_len] = 1'b1; exp_len++;
            for (int i = 17; i >= 0; i--) begin exp_bits[exp_len] = ext[i]; exp_len++; end
        end
        exp_bits[exp_len] = rtr; exp_len++;
    endtask

    // Sends one field; fault_idx forces rx_bit=fault_val at that bit. stop_at >= 0
    // returns before sampling that bit, leaving the frame in flight.
    task automatic run_frame(input string tag, input logic [10:0] id, input logic rtr,
                             input logic ide, input logic [17:0] ext,
                             input int fault_idx, input logic fault_val, input int stop_at);
        int   outcome;  // 0 won, 1 lost, 2 bit error
        int   gap;
        logic rx;
        logic [2:0] exp_st;
        build_field(id, rtr, ide, ext);
        tx_id  = id;
        tx_rtr = rtr;
`ifdef CAN_EXT_ID_EN
        tx_ide    = ide;
        tx_id_ext = ext;
`endif
        @(negedge clock);
        sof_complete = 1'b1;
        sample_point = 1'b1;
        rx_bit       = 1'b0;
        @(negedge clock);
        sof_complete = 1'b0;
        sample_point = 1'b0;
        rx_bit       = 1'b1;
        tx_id        = 11'($urandom);
        tx_rtr       = 1'($urandom);
`ifdef CAN_EXT_ID_EN
        tx_ide    = 1'($urandom);
        tx_id_ext = 18'($urandom);
`endif
        outcome = 0;
        for (int i = 0; i < exp_len; i++) begin
            if (i == stop_at) return;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                sof_complete = ($urandom_range(0, 2) == 0);
                @(negedge clock);
            end
            sof_complete = 1'b0;
            checks++;
            if (tx_bit !== exp_bits[i])
                $display("FAIL %s tx_bit[%0d]: got %b expected %b", tag, i, tx_bit, exp_bits[i]);
            if (tx_bit !== exp_bits[i]) errors++;
            checks++;
            if (arb_active !== 1'b1 || {arb_lost, arb_complete, bit_error} !== 3'b000) begin
                errors++;
                $display("FAIL %s active[%0d]: got act=%b st=%b expected act=1 st=000",
                         tag, i, arb_active, {arb_lost, arb_complete, bit_error});
            end
            rx = (i == fault_idx) ? fault_val : exp_bits[i];
            sample_point = 1'b1;
            rx_bit       = rx;
            @(negedge clock);
            sample_point = 1'b0;
            rx_bit       = 1'b1;
            if (exp_bits[i] && !rx) begin outcome = 1; break; end
            if (!exp_bits[i] && rx) begin outcome = 2; break; end
        end
        exp_st = {outcome == 1, outcome == 0, outcome == 2};
        checks++;
        if ({arb_lost, arb_complete, bit_error} !== exp_st || tx_bit !== 1'b1 || arb_active !== 1'b0) begin
            errors++;
            $display("FAIL %s outcome: got lost/cmp/err=%b tx=%b act=%b expected %b tx=1 act=0",
                     tag, {arb_lost, arb_complete, bit_error}, tx_bit, arb_active, exp_st);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if ({arb_lost, arb_complete, bit_error} !== 3'b000 || tx_bit !== 1'b1 || arb_active !== 1'b0) begin
                errors++;
                $display("FAIL %s post[%0d]: got st=%b tx=%b act=%b expected st=000 tx=1 act=0",
                         tag, k, {arb_lost, arb_complete, bit_error}, tx_bit, arb_active);
            end
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        enable       = 1'b1;
        sof_complete = 1'b0;
        sample_point = 1'b0;
        rx_bit       = 1'b1;
        tx_id        = '0;
        tx_rtr       = 1'b0;
`ifdef CAN_EXT_ID_EN
        tx_ide    = 1'b0;
        tx_id_ext = '0;
`endif
        #12;
        checks++;
        if ({tx_bit, arb_active, arb_complete, arb_lost, bit_error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset: got %b expected 10000",
                     {tx_bit, arb_active, arb_complete, arb_lost, bit_error});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({tx_bit, arb_active, arb_complete, arb_lost, bit_error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 10000",
                     {tx_bit, arb_active, arb_complete, arb_lost, bit_error});
        end
    endtask

    task automatic test_directed();
        run_frame("id123_echo", 11'h123, 1'b0, 1'b0, '0, -1, 1'b1, -1);
        run_frame("id7ff_lost", 11'h7FF, 1'b0, 1'b0, '0, 3, 1'b0, -1);
        run_frame("id000_err",  11'h000, 1'b0, 1'b0, '0, 0, 1'b1, -1);
        run_frame("id000_rtr",  11'h000, 1'b1, 1'b0, '0, 11, 1'b0, -1);
    endtask

    task automatic test_random();
        logic ide;
        for (int n = 0; n < 30; n++) begin
`ifdef CAN_EXT_ID_EN
            ide = 1'($urandom);
`else
            ide = 1'b0;
`endif
            run_frame("random", 11'($urandom), 1'($urandom), ide, 18'($urandom),
                      $urandom_range(0, 45), 1'($urandom), -1);
        end
    endtask

`ifdef CAN_EXT_ID_EN
    task automatic test_ext_id();
        run_frame("ext_echo", 11'h555, 1'b0, 1'b1, 18'h2AAAA, -1, 1'b1, -1);
        run_frame("ext_lost", 11'h555, 1'b1, 1'b1, 18'h2AAAA, 12, 1'b0, -1);
    endtask
`endif

    task automatic test_enable_drop();
        run_frame("en_drop", 11'h2C5, 1'b1, 1'b0, '0, -1, 1'b1, 5);
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if ({tx_bit, arb_active, arb_complete, arb_lost, bit_error} !== 5'b10000) begin
            errors++;
            $display("FAIL enable_drop: got %b expected 10000",
                     {tx_bit, arb_active, arb_complete, arb_lost, bit_error});
        end
        enable = 1'b1;
        run_frame("en_restart", 11'h2C5, 1'b1, 1'b0, '0, -1, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        run_frame("rst_mid", 11'h4A9, 1'b0, 1'b0, '0, -1, 1'b1, $urandom_range(1, 10));
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_bit, arb_active, arb_complete, arb_lost, bit_error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected 10000",
                     {tx_bit, arb_active, arb_complete, arb_lost, bit_error});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({tx_bit, arb_active, arb_complete, arb_lost, bit_error} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: got %b expected 10000",
                         k, {tx_bit, arb_active, arb_complete, arb_lost, bit_error});
            end
        end
        run_frame("rst_restart", 11'h4A9, 1'b0, 1'b0, '0, -1, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef CAN_EXT_ID_EN
        test_ext_id();
`endif
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
